// File: rtl/cpu_fpu_f2i.sv
// Multi-cycle IEEE-754 to integer converter: bit-serial shifter plus RISC-V rounding.
// Define CPU_FPU_F2I_ROUNDING_EN to honour i_rm; otherwise every conversion truncates (RTZ).
module cpu_fpu_f2i #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int INT_WIDTH = 32
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_request,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] i_op1,
  input  logic                         i_signed,
  input  logic [2:0]                   i_rm,
  output logic                         o_ready,
  output logic [INT_WIDTH-1:0]         o_result,
  output logic                         o_invalid,
  output logic                         o_inexact
);
  localparam int OP_W  = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int MAG_W = (INT_WIDTH > MAN_WIDTH + 1) ? INT_WIDTH : MAN_WIDTH + 1;
  localparam int WIDE  = MAG_W + 1;
  localparam int E_W   = EXP_WIDTH + 2;
  localparam int CNT_W = 8;
  localparam int BIAS  = (1 << (EXP_WIDTH - 1)) - 1;

  localparam logic [WIDE-1:0] ONE_W     = 1;
  localparam logic [WIDE-1:0] LIM_S_POS = (ONE_W << (INT_WIDTH - 1)) - ONE_W;
  localparam logic [WIDE-1:0] LIM_S_NEG = ONE_W << (INT_WIDTH - 1);
  localparam logic [WIDE-1:0] LIM_U_POS = (ONE_W << INT_WIDTH) - ONE_W;

  typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, ROUND, DONE} state_t;

  state_t           state_reg;
  logic [OP_W-1:0]  op_reg;
  logic             signed_reg;
  logic [2:0]       rm_reg;
  logic [1:0]       cls_cnt_reg;
  logic [CNT_W-1:0] sh_cnt_reg;
  logic             left_reg;
  logic [MAG_W-1:0] mag_reg;
  logic             guard_reg;
  logic             sticky_reg;

  logic                 sign;
  logic [EXP_WIDTH-1:0] exp_field;
  logic [MAN_WIDTH-1:0] frac_field;
  logic signed [E_W-1:0] e_unb;
  logic signed [E_W-1:0] rsh_raw;
  logic                 is_left;
  logic [CNT_W-1:0]     shift_cnt;

  assign sign       = op_reg[OP_W-1];
  assign exp_field  = op_reg[OP_W-2 -: EXP_WIDTH];
  assign frac_field = op_reg[MAN_WIDTH-1:0];
  assign e_unb      = $signed({2'b00, exp_field}) - $signed(E_W'(BIAS));
  assign rsh_raw    = $signed(E_W'(MAN_WIDTH)) - e_unb;
  assign is_left    = e_unb >= $signed(E_W'(MAN_WIDTH));

  // Right shifts stop at MAN_WIDTH+2: by then the whole significand sits in sticky.
  always_comb begin
    if (is_left)
      shift_cnt = CNT_W'(e_unb - $signed(E_W'(MAN_WIDTH)));
    else if (rsh_raw > $signed(E_W'(MAN_WIDTH + 2)))
      shift_cnt = CNT_W'(MAN_WIDTH + 2);
    else
      shift_cnt = CNT_W'(rsh_raw);
  end

  logic [INT_WIDTH-1:0] sat_max;
  logic [INT_WIDTH-1:0] sat_min;
  assign sat_max = signed_reg ? {1'b0, {(INT_WIDTH-1){1'b1}}} : {INT_WIDTH{1'b1}};
  assign sat_min = signed_reg ? {1'b1, {(INT_WIDTH-1){1'b0}}} : '0;

  logic                 is_special;
  logic [INT_WIDTH-1:0] spec_result;
  logic                 spec_invalid;

  always_comb begin
    is_special   = 1'b1;
    spec_result  = '0;
    spec_invalid = 1'b0;
    if (exp_field == '0) begin
      spec_result = '0;
    end else if (&exp_field) begin
      spec_invalid = 1'b1;
      spec_result  = ((frac_field != '0) || !sign) ? sat_max : sat_min;
    end else if (e_unb >= $signed(E_W'(INT_WIDTH))) begin
      spec_invalid = 1'b1;
      spec_result  = sign ? sat_min : sat_max;
    end else begin
      is_special = 1'b0;
    end
  end

  logic inexact_bits;
  logic round_inc;
  assign inexact_bits = guard_reg | sticky_reg;

`ifdef CPU_FPU_F2I_ROUNDING_EN
  always_comb begin
    case (rm_reg)
      3'b000:  round_inc = guard_reg & (sticky_reg | mag_reg[0]);
      3'b010:  round_inc = sign & inexact_bits;
      3'b011:  round_inc = ~sign & inexact_bits;
      3'b100:  round_inc = guard_reg;
      default: round_inc = 1'b0;
    endcase
  end
`else
  logic unused_rm;
  assign unused_rm = ^rm_reg;
  assign round_inc = 1'b0;
`endif

  logic [WIDE-1:0]      rounded;
  logic                 overflow;
  logic [INT_WIDTH-1:0] rnd_result;

  assign rounded    = {1'b0, mag_reg} + WIDE'(round_inc);
  assign overflow   = sign ? (rounded > (signed_reg ? LIM_S_NEG : '0))
                           : (rounded > (signed_reg ? LIM_S_POS : LIM_U_POS));
  assign rnd_result = sign ? (INT_WIDTH'(0) - rounded[INT_WIDTH-1:0]) : rounded[INT_WIDTH-1:0];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      o_ready     <= 1'b0;
      o_result    <= '0;
      o_invalid   <= 1'b0;
      o_inexact   <= 1'b0;
      op_reg      <= '0;
      signed_reg  <= 1'b0;
      rm_reg      <= 3'b000;
      cls_cnt_reg <= 2'd0;
      sh_cnt_reg  <= '0;
      left_reg    <= 1'b0;
      mag_reg     <= '0;
      guard_reg   <= 1'b0;
      sticky_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_request) begin
            op_reg      <= i_op1;
            signed_reg  <= i_signed;
            rm_reg      <= i_rm;
            cls_cnt_reg <= 2'd0;
            state_reg   <= CLASSIFY;
          end
        end
        // Three cycles in CLASSIFY align the special path to a fixed 3-cycle latency.
        CLASSIFY: begin
          if (cls_cnt_reg != 2'd2) begin
            cls_cnt_reg <= cls_cnt_reg + 2'd1;
          end else if (is_special) begin
            o_result  <= spec_result;
            o_invalid <= spec_invalid;
            o_inexact <= 1'b0;
            o_ready   <= 1'b1;
            state_reg <= DONE;
          end else begin
            mag_reg    <= MAG_W'({1'b1, frac_field});
            guard_reg  <= 1'b0;
            sticky_reg <= 1'b0;
            left_reg   <= is_left;
            sh_cnt_reg <= shift_cnt;
            state_reg  <= (shift_cnt == '0) ? ROUND : SHIFT;
          end
        end
        SHIFT: begin
          if (left_reg) begin
            mag_reg <= {mag_reg[MAG_W-2:0], 1'b0};
          end else begin
            mag_reg    <= {1'b0, mag_reg[MAG_W-1:1]};
            guard_reg  <= mag_reg[0];
            sticky_reg <= sticky_reg | guard_reg;
          end
          sh_cnt_reg <= sh_cnt_reg - CNT_W'(1);
          if (sh_cnt_reg == CNT_W'(1))
            state_reg <= ROUND;
        end
        ROUND: begin
          o_result  <= overflow ? (sign ? sat_min : sat_max) : rnd_result;
          o_invalid <= overflow;
          o_inexact <= inexact_bits & ~overflow;
          o_ready   <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          if (!i_request) begin
            o_ready   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_fpu_f2i.sv
// Directed bench for cpu_fpu_f2i (8/23/32) with an expected-result scoreboard queue.
module tb_cpu_fpu_f2i;
`ifdef CPU_FPU_F2I_ROUNDING_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  logic        i_clock;
  logic        i_reset;
  logic        i_request;
  logic [31:0] i_op1;
  logic        i_signed;
  logic [2:0]  i_rm;
  logic        o_ready;
  logic [31:0] o_result;
  logic        o_invalid;
  logic        o_inexact;

  cpu_fpu_f2i #(.EXP_WIDTH(8), .MAN_WIDTH(23), .INT_WIDTH(32)) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_request(i_request),
    .i_op1    (i_op1),
    .i_signed (i_signed),
    .i_rm     (i_rm),
    .o_ready  (o_ready),
    .o_result (o_result),
    .o_invalid(o_invalid),
    .o_inexact(o_inexact)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] res;
    logic        inv;
    logic        nx;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  task automatic convert(input string tag, input logic [31:0] op, input logic sgn,
                         input logic [2:0] rm, input logic [31:0] res, input logic inv,
                         input logic nx, input int lat, input bit drop_early);
    exp_t e;
    int   cyc;
    bit   seen;
    e = '{res, inv, nx, lat};
    exp_q.push_back(e);
    @(negedge i_clock);
    i_op1     = op;
    i_signed  = sgn;
    i_rm      = rm;
    i_request = 1'b1;
    @(posedge i_clock);
    #1;
    i_op1    = ~op;
    i_signed = ~sgn;
    i_rm     = ~rm;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge i_clock);
      #1;
      cyc++;
      if (drop_early && cyc == 2) i_request = 1'b0;
      if (o_ready) seen = 1'b1;
    end
    e = exp_q.pop_front();
    check({tag, " ready"}, 64'(seen), 64'd1);
    if (seen) begin
      $display("conv %-12s op=0x%08h sgn=%0d rm=%0d -> result=0x%08h nv=%0b nx=%0b lat=%0d",
               tag, op, sgn, rm, o_result, o_invalid, o_inexact, cyc);
      check({tag, " latency"}, 64'(cyc), 64'(e.lat));
      check({tag, " result"}, 64'(o_result), 64'(e.res));
      check({tag, " invalid"}, 64'(o_invalid), 64'(e.inv));
      check({tag, " inexact"}, 64'(o_inexact), 64'(e.nx));
      if (!drop_early) begin
        @(posedge i_clock);
        #1;
        check({tag, " hold ready"}, 64'(o_ready), 64'd1);
        check({tag, " hold result"}, 64'(o_result), 64'(e.res));
        i_request = 1'b0;
      end
      @(posedge i_clock);
      #1;
      check({tag, " ready low"}, 64'(o_ready), 64'd0);
      check({tag, " kept result"}, 64'(o_result), 64'(e.res));
    end else begin
      i_request = 1'b0;
    end
  endtask

  int ready_seen;

  initial begin
    i_reset   = 1'b1;
    i_request = 1'b0;
    i_op1     = 32'h0;
    i_signed  = 1'b0;
    i_rm      = 3'b000;
    repeat (3) @(posedge i_clock);
    #1;
    check("reset ready", 64'(o_ready), 64'd0);
    check("reset result", 64'(o_result), 64'd0);
    check("reset invalid", 64'(o_invalid), 64'd0);
    check("reset inexact", 64'(o_inexact), 64'd0);
    @(negedge i_clock);
    i_reset = 1'b0;

    convert("one_rtz",   32'h3F800000, 1'b1, 3'b001, 32'h00000001, 1'b0, 1'b0, 27, 1'b0);
    convert("m2p5_rne",  32'hC0200000, 1'b1, 3'b000, 32'hFFFFFFFE, 1'b0, 1'b1, 26, 1'b0);
    convert("m2p5_rmm",  32'hC0200000, 1'b1, 3'b100, RND_EN ? 32'hFFFFFFFD : 32'hFFFFFFFE, 1'b0, 1'b1, 26, 1'b0);
    convert("m2p5_rtz",  32'hC0200000, 1'b1, 3'b001, 32'hFFFFFFFE, 1'b0, 1'b1, 26, 1'b0);
    convert("3e9_s",     32'h4F32D05E, 1'b1, 3'b001, 32'h7FFFFFFF, 1'b1, 1'b0, 12, 1'b0);
    convert("3e9_u",     32'h4F32D05E, 1'b0, 3'b001, 32'hB2D05E00, 1'b0, 1'b0, 12, 1'b0);
    convert("nan_s",     32'h7FC00000, 1'b1, 3'b000, 32'h7FFFFFFF, 1'b1, 1'b0, 3, 1'b0);
    convert("nan_u",     32'h7FC00000, 1'b0, 3'b000, 32'hFFFFFFFF, 1'b1, 1'b0, 3, 1'b0);
    convert("ninf_s",    32'hFF800000, 1'b1, 3'b000, 32'h80000000, 1'b1, 1'b0, 3, 1'b0);
    convert("pinf_u",    32'h7F800000, 1'b0, 3'b000, 32'hFFFFFFFF, 1'b1, 1'b0, 3, 1'b0);
    convert("mhalf_u",   32'hBF000000, 1'b0, 3'b001, 32'h00000000, 1'b0, 1'b1, 28, 1'b0);
    convert("mone_u",    32'hBF800000, 1'b0, 3'b001, 32'h00000000, 1'b1, 1'b0, 27, 1'b0);
    convert("subnorm",   32'h00000001, 1'b1, 3'b011, 32'h00000000, 1'b0, 1'b0, 3, 1'b0);
    convert("m2p32_s",   32'hCF800000, 1'b1, 3'b000, 32'h80000000, 1'b1, 1'b0, 3, 1'b0);
    convert("m2p31_s",   32'hCF000000, 1'b1, 3'b000, 32'h80000000, 1'b0, 1'b0, 12, 1'b0);
    convert("p2p31_u",   32'h4F000000, 1'b0, 3'b000, 32'h80000000, 1'b0, 1'b0, 12, 1'b0);
    convert("1p5_rup",   32'h3FC00000, 1'b1, 3'b011, RND_EN ? 32'h00000002 : 32'h00000001, 1'b0, 1'b1, 27, 1'b0);
    convert("m1p5_rdn",  32'hBFC00000, 1'b1, 3'b010, RND_EN ? 32'hFFFFFFFE : 32'hFFFFFFFF, 1'b0, 1'b1, 27, 1'b0);
    convert("1p5_rm101", 32'h3FC00000, 1'b1, 3'b101, 32'h00000001, 1'b0, 1'b1, 27, 1'b0);
    convert("half_rne",  32'h3F000000, 1'b1, 3'b000, 32'h00000000, 1'b0, 1'b1, 28, 1'b0);
    convert("minnorm",   32'h00800000, 1'b1, 3'b001, 32'h00000000, 1'b0, 1'b1, 29, 1'b0);
    convert("drop_early",32'h40400000, 1'b1, 3'b001, 32'h00000003, 1'b0, 1'b0, 26, 1'b1);
    convert("p2p31_s",   32'h4F000000, 1'b1, 3'b000, 32'h7FFFFFFF, 1'b1, 1'b0, 12, 1'b0);

    // Reset while the shifter is running must abandon the conversion silently.
    @(negedge i_clock);
    i_op1     = 32'h3F800000;
    i_signed  = 1'b1;
    i_rm      = 3'b001;
    i_request = 1'b1;
    @(posedge i_clock);
    repeat (6) @(posedge i_clock);
    @(negedge i_clock);
    i_reset   = 1'b1;
    i_request = 1'b0;
    @(posedge i_clock);
    #1;
    check("midreset ready", 64'(o_ready), 64'd0);
    check("midreset result", 64'(o_result), 64'd0);
    check("midreset invalid", 64'(o_invalid), 64'd0);
    check("midreset inexact", 64'(o_inexact), 64'd0);
    @(negedge i_clock);
    i_reset = 1'b0;
    ready_seen = 0;
    repeat (40) begin
      @(posedge i_clock);
      #1;
      if (o_ready) ready_seen++;
    end
    check("midreset no ready", 64'(ready_seen), 64'd0);
    $display("conv %-12s reset during SHIFT, ready cycles seen=%0d", "midreset", ready_seen);

    convert("after_rst", 32'h3F800000, 1'b1, 3'b001, 32'h00000001, 1'b0, 1'b0, 27, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cpu_fpu_f2i.md
CPU_FPU_F2I -- requirements
Module: CPU_FPU_F2I

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, input exponent field width (8 or 11).
REQ-002 SHALL have parameter MAN_WIDTH, default 23, input fraction field width (23 or 52).
REQ-003 SHALL have parameter INT_WIDTH, default 32, result width (32 or 64).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port i_clock, input, 1, rising-edge clock.
REQ-006 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_request, input, 1, level request, held until o_ready.
REQ-008 SHALL have port i_op1, input, 1+EXP_WIDTH+MAN_WIDTH, IEEE-754 operand.
REQ-009 SHALL have port i_signed, input, 1, 1 = signed result, 0 = unsigned.
REQ-010 SHALL have port i_rm, input, 3, RISC-V rounding mode.
REQ-011 SHALL have port o_ready, output, 1, result valid.
REQ-012 SHALL have port o_result, output, INT_WIDTH, converted integer.
REQ-013 SHALL have port o_invalid, output, 1, NV flag.
REQ-014 SHALL have port o_inexact, output, 1, NX flag.

Function
REQ-015 SHALL use FSM states IDLE, CLASSIFY, SHIFT, ROUND, DONE.
- IDLE samples i_op1, i_signed and i_rm when i_request=1, then moves to CLASSIFY.
REQ-016 CLASSIFY SHALL resolve special cases and jump directly to DONE:
- exponent field 0 (zero or subnormal) -> 0, no flags.
- NaN -> max, invalid.
- +Inf -> max, invalid; -Inf -> min, invalid.
- unbiased e >= INT_WIDTH -> saturate by sign, invalid.
REQ-017 max/min: signed = 2^(W-1)-1 / -2^(W-1); unsigned = 2^W-1 / 0.
REQ-018 SHIFT SHALL move the significand {1,frac} one bit per cycle.
- s = e-MAN_WIDTH cycles left when e >= MAN_WIDTH.
- otherwise s = min(MAN_WIDTH-e, MAN_WIDTH+2) cycles right.
- right shifts collect guard and sticky bits.
REQ-019 ROUND SHALL apply i_rm to the magnitude.
- 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 act as RTZ.
- then negate if the sign is set.
- then range-check: out of range -> saturate per REQ-017, invalid, inexact cleared.
REQ-020 Negative input with i_signed=0:
- rounded magnitude 0 -> result 0, inexact only.
- otherwise -> 0, invalid.
REQ-021 o_inexact SHALL be 1 iff guard|sticky is nonzero and invalid is 0.
REQ-022 Latency, counted from the IDLE sampling edge:
- o_ready rises 4+s cycles later on the normal path.
- o_ready rises 3 cycles later on the special path.
REQ-023 DONE SHALL drive o_ready=1 with result and flags stable while i_request=1.
- i_request=0 in DONE -> o_ready=0 next cycle, return to IDLE.
REQ-024 i_request falling before DONE SHALL be ignored; the conversion completes, then REQ-023 applies.
REQ-025 Outputs SHALL only change on entry to DONE or on leaving DONE (o_ready only).

Reset
REQ-026 i_reset=1 at a clock edge SHALL force IDLE with o_ready, o_result, o_invalid, o_inexact = 0, and SHALL override all other activity.
REQ-027 Reset mid-conversion SHALL discard the operation; no o_ready pulse follows.

Configuration
REQ-028 Macro CPU_FPU_F2I_ROUNDING_EN, when defined, SHALL enable all i_rm modes per REQ-019.
REQ-029 Without CPU_FPU_F2I_ROUNDING_EN:
- i_rm is ignored and every conversion is RTZ.
- the ROUND state still exists (latency unchanged).
- o_inexact is still reported.

Verification (defaults 8/23/32)
REQ-030 0x3F800000, signed, RTZ -> 0x00000001, no flags, o_ready at cycle 4+23=27.
REQ-031 0xC0200000 (-2.5), signed -> RNE 0xFFFFFFFE, RMM 0xFFFFFFFD, RTZ 0xFFFFFFFE; inexact in all three.
REQ-032 0x4F32D05E (3e9) -> signed 0x7FFFFFFF invalid; unsigned 0xB2D05E00, no flags.
REQ-033 0x7FC00000 -> 0x7FFFFFFF invalid; 0xFF800000 signed -> 0x80000000 invalid; 0xBF000000 unsigned RTZ -> 0, inexact only.
REQ-034 0xBF800000 unsigned -> 0, invalid.
REQ-035 Handshake and reset:
- reset pulsed during SHIFT -> no o_ready, outputs 0.
- next request completes correctly.
- i_request dropped in DONE -> o_ready low next cycle.
